// File: rtl/pps_sync_gen.sv
// pps_sync_gen: measures an external PPS, tracks lock with an UNLOCKED/ACQUIRE/LOCKED/HOLDOVER
// state machine, and produces a local PPS pulse that is resynchronised to valid external edges.
module pps_sync_gen #(
   parameter int unsigned NOMINAL = 125000000,
   parameter int unsigned TOL     = 1250,
   parameter int unsigned PULSE_W = 12500000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        pps_in,
   input  logic        enable,
   input  logic        force_free,
   output logic        pps_out,
   output logic        pps_tick,
   output logic        locked,
   output logic [31:0] period,
   output logic [7:0]  miss_cnt
);

   typedef enum logic [1:0] {StUnlocked, StAcquire, StLocked, StHoldover} state_e;

   localparam logic [32:0] PerLo      = (NOMINAL > TOL) ? 33'(NOMINAL - TOL) : 33'd0;
   localparam logic [32:0] PerHi      = 33'(NOMINAL) + 33'(TOL);
   localparam logic [31:0] CtrTimeout = 32'(NOMINAL + TOL);
   localparam logic [31:0] GenLast    = 32'(NOMINAL - 1);
   localparam logic [31:0] WidthLoad  = 32'(PULSE_W - 1);

   // Input synchronizer and edge detection
   logic        s1_q, s2_q, s3_q;
   logic [1:0]  fill_q;
   logic        armed_q;
   logic        ext_edge;

   // Measurement and lock tracking
   logic [31:0] ctr_q, ctr_d;
   state_e      state_q, state_d;
   logic [31:0] period_q, period_d;
   logic [7:0]  miss_q, miss_d;
   logic [31:0] hold_q, hold_d;
   logic [32:0] meas;
   logic        valid;
   logic        timeout;
   logic        miss_inc;
   logic        resync;

   // Local generator and pulse shaping
   logic [31:0] gen_q, gen_d;
   logic        tick_q, tick_d;
   logic [31:0] width_q, width_d;
   logic        out_q, out_d;

   // Synchronize pps_in; armed_q blocks edges until a real 0 sample has reached s2 after reset,
   // so a pps_in held high across reset release is not mistaken for a rising edge.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         fill_q  <= 2'd0;
         armed_q <= 1'b0;
      end else begin
         s1_q <= pps_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
         if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
         if (fill_q == 2'd2 && !s2_q) armed_q <= 1'b1;
      end
   end

   assign ext_edge = s2_q & ~s3_q & armed_q;
   assign meas     = {1'b0, ctr_q} + 33'd1;
   assign valid    = (meas >= PerLo) && (meas <= PerHi);
   assign timeout  = (ctr_q == CtrTimeout);

   // Period counter, lock state machine and missed-second accounting
   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      miss_d   = miss_q;
      hold_d   = '0;
      miss_inc = 1'b0;
      resync   = 1'b0;
      if (ext_edge) begin
         ctr_d    = '0;
         period_d = meas[32] ? '1 : meas[31:0];
      end else if (ctr_q == '1) begin
         ctr_d = ctr_q;
      end else begin
         ctr_d = ctr_q + 32'd1;
      end
      case (state_q)
         StUnlocked: begin
            if (ext_edge) state_d = StAcquire;
         end
         StAcquire: begin
            if (ext_edge) begin
               if (valid) begin
                  state_d = StLocked;
                  resync  = 1'b1;
               end
            end else if (timeout) begin
               state_d = StUnlocked;
            end
         end
         StLocked: begin
            if (ext_edge) begin
               if (valid) resync = 1'b1;
               else       state_d = StAcquire;
            end else if (timeout) begin
               state_d  = StHoldover;
               miss_inc = 1'b1;
            end
         end
         StHoldover: begin
            if (ext_edge) begin
               state_d = StAcquire;
            end else if (hold_q == GenLast) begin
               miss_inc = 1'b1;
            end else begin
               hold_d = hold_q + 32'd1;
            end
         end
         default: state_d = StUnlocked;
      endcase
      if (miss_inc && miss_q != 8'hff) miss_d = miss_q + 8'd1;
      if (force_free) resync = 1'b0;
   end

   // Free-running generator; a resync restarts the second and wins over a coincident wrap
   always_comb begin
      gen_d  = gen_q + 32'd1;
      tick_d = 1'b0;
      if (!enable) begin
         gen_d = '0;
      end else if (resync || gen_q == GenLast) begin
         gen_d  = '0;
         tick_d = 1'b1;
      end
   end

   // Pulse stretcher: a tick (re)loads the width count, output stays high through count 0
   always_comb begin
      width_d = '0;
      out_d   = 1'b0;
      if (enable) begin
         if (tick_d) begin
            width_d = WidthLoad;
            out_d   = 1'b1;
         end else if (width_q != '0) begin
            width_d = width_q - 32'd1;
            out_d   = 1'b1;
         end
      end
   end

   // State registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ctr_q    <= '0;
         state_q  <= StUnlocked;
         period_q <= '0;
         miss_q   <= '0;
         hold_q   <= '0;
         gen_q    <= '0;
         tick_q   <= 1'b0;
         width_q  <= '0;
         out_q    <= 1'b0;
      end else begin
         ctr_q    <= ctr_d;
         state_q  <= state_d;
         period_q <= period_d;
         miss_q   <= miss_d;
         hold_q   <= hold_d;
         gen_q    <= gen_d;
         tick_q   <= tick_d;
         width_q  <= width_d;
         out_q    <= out_d;
      end
   end

   assign pps_out  = out_q & enable;
   assign pps_tick = tick_q & enable;
   assign locked   = (state_q == StLocked);
   assign period   = period_q;
   assign miss_cnt = miss_q;

endmodule

// File: tb/tb_pps_sync_gen.sv
// Bench for pps_sync_gen: timestamp-based reference model checked every cycle, a phase table
// with hand-derived lock/period/miss expectations, randomized windows and reset corner cases.
module tb_pps_sync_gen;

   localparam int N = 100;
   localparam int T = 2;
   localparam int P = 10;

   logic        CLK = 1'b0;
   logic        RST;
   logic        pps_in;
   logic        enable;
   logic        force_free;
   logic        pps_out;
   logic        pps_tick;
   logic        locked;
   logic [31:0] period;
   logic [7:0]  miss_cnt;

   pps_sync_gen #(.NOMINAL(N), .TOL(T), .PULSE_W(P)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .pps_in     (pps_in),
      .enable     (enable),
      .force_free (force_free),
      .pps_out    (pps_out),
      .pps_tick   (pps_tick),
      .locked     (locked),
      .period     (period),
      .miss_cnt   (miss_cnt)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: everything is expressed as posedge timestamps since reset release.
   typedef enum {MUnlocked, MAcquire, MLocked, MHoldover} mstate_t;
   mstate_t m_st;
   int      m_k;          // posedge index since reset release
   bit      smp_q[$];     // smp_q[i] = pps_in sampled at posedge i+1
   int      m_anchor;     // posedge of last detected edge (0 = reset)
   int      m_period;
   int      m_miss;
   int      m_next_tick;  // posedge at which the free-running second next expires
   int      m_last_tick;
   bit      m_tick;
   bit      m_en;

   task automatic model_reset();
      m_st = MUnlocked;
      m_k = 0;
      smp_q.delete();
      m_anchor = 0;
      m_period = 0;
      m_miss = 0;
      m_next_tick = N;
      m_last_tick = -1000000;
      m_tick = 1'b0;
   endtask

   task automatic bump_miss();
      if (m_miss < 255) m_miss++;
   endtask

   task automatic model_posedge(input bit pin, input bit en, input bit ff);
      bit e;
      bit v;
      bit rs;
      int meas;
      int ctr;
      m_k++;
      m_en = en;
      smp_q.push_back(pin);
      // a rising edge is acted on two posedges after it was first sampled
      e = 1'b0;
      if (m_k >= 4) e = (smp_q[m_k-4] == 1'b0) && (smp_q[m_k-3] == 1'b1);
      ctr  = m_k - m_anchor - 1;
      meas = m_k - m_anchor;
      v    = (meas >= N - T) && (meas <= N + T);
      rs   = 1'b0;
      if (e) begin
         case (m_st)
            MUnlocked: m_st = MAcquire;
            MAcquire:  if (v) begin m_st = MLocked; rs = 1'b1; end
            MLocked:   if (v) rs = 1'b1; else m_st = MAcquire;
            MHoldover: m_st = MAcquire;
            default:   m_st = MUnlocked;
         endcase
         m_period = meas;
         m_anchor = m_k;
      end else if (m_st == MAcquire && ctr == N + T) begin
         m_st = MUnlocked;
      end else if (m_st == MLocked && ctr == N + T) begin
         m_st = MHoldover;
         bump_miss();
      end else if (m_st == MHoldover && ctr > N + T && (ctr - (N + T)) % N == 0) begin
         bump_miss();
      end
      if (ff) rs = 1'b0;
      if (!en) begin
         m_tick = 1'b0;
         m_next_tick = m_k + N;
         m_last_tick = -1000000;
      end else if (rs || m_k == m_next_tick) begin
         m_tick = 1'b1;
         m_next_tick = m_k + N;
         m_last_tick = m_k;
      end else begin
         m_tick = 1'b0;
      end
   endtask

   task automatic check_cycle();
      logic       e_out;
      logic       e_tick;
      logic       e_lock;
      e_out  = m_en && (m_k - m_last_tick < P);
      e_tick = m_tick & m_en;
      e_lock = (m_st == MLocked);
      vectors++;
      if (pps_out !== e_out || pps_tick !== e_tick || locked !== e_lock ||
          period !== 32'(m_period) || miss_cnt !== 8'(m_miss)) begin
         miscompares++;
         $display("FAIL cycle k=%0d: out=%b tick=%b locked=%b period=%0d miss=%0d, required out=%b tick=%b locked=%b period=%0d miss=%0d",
                  m_k, pps_out, pps_tick, locked, period, miss_cnt,
                  e_out, e_tick, e_lock, m_period, m_miss);
      end
   endtask

   task automatic chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // One clock: drive, let the posedge happen, update the model, compare on the negedge.
   task automatic step(input bit pin, input bit en, input bit ff);
      pps_in = pin;
      enable = en;
      force_free = ff;
      @(posedge CLK);
      model_posedge(pin, en, ff);
      @(negedge CLK);
      check_cycle();
   endtask

   // One window: low for gap-hi cycles, then high for hi; consecutive rises are gap apart.
   task automatic pulse(input int gap, input int hi, input bit en, input bit ff);
      for (int i = 0; i < gap - hi; i++) step(1'b0, en, ff);
      for (int i = 0; i < hi; i++) step(1'b1, en, ff);
   endtask

   typedef struct {
      int gap;
      int npulse;     // 0 = idle for gap cycles
      bit en;
      bit ff;
      bit chk_per;
      int exp_per;
      bit exp_lock;
      int exp_miss;
   } phase_t;

   function automatic phase_t mk(input int gap, input int np, input bit en, input bit ff,
                                 input bit cp, input int ep, input bit el, input int em);
      phase_t p;
      p.gap = gap; p.npulse = np; p.en = en; p.ff = ff;
      p.chk_per = cp; p.exp_per = ep; p.exp_lock = el; p.exp_miss = em;
      return p;
   endfunction

   phase_t ph[20];

   initial begin
      int found;
      ph[0]  = mk(100, 3, 1'b1, 1'b0, 1'b1, 100, 1'b1, 0);  // acquire then lock
      ph[1]  = mk( 95, 1, 1'b1, 1'b0, 1'b1,  95, 1'b0, 0);  // short second drops to acquire
      ph[2]  = mk(100, 1, 1'b1, 1'b0, 1'b1, 100, 1'b1, 0);  // relock
      ph[3]  = mk(150, 0, 1'b1, 1'b0, 1'b1, 100, 1'b0, 1);  // timeout -> holdover
      ph[4]  = mk(100, 0, 1'b1, 1'b0, 1'b1, 100, 1'b0, 2);  // another missed second
      ph[5]  = mk(100, 1, 1'b1, 1'b0, 1'b0,   0, 1'b0, 3);  // holdover edge -> acquire
      ph[6]  = mk(100, 2, 1'b1, 1'b0, 1'b1, 100, 1'b1, 3);
      ph[7]  = mk(137, 1, 1'b1, 1'b1, 1'b1, 137, 1'b0, 4);  // 37-cycle offset, free-run
      ph[8]  = mk(100, 3, 1'b1, 1'b1, 1'b1, 100, 1'b1, 4);  // locked, no resync
      ph[9]  = mk(100, 1, 1'b1, 1'b0, 1'b1, 100, 1'b1, 4);  // resync returns
      ph[10] = mk(100, 3, 1'b0, 1'b0, 1'b1, 100, 1'b1, 4);  // disabled, still measuring
      ph[11] = mk(100, 1, 1'b1, 1'b0, 1'b1, 100, 1'b1, 4);
      ph[12] = mk( 98, 1, 1'b1, 1'b0, 1'b1,  98, 1'b1, 4);  // lower tolerance edge
      ph[13] = mk(102, 1, 1'b1, 1'b0, 1'b1, 102, 1'b1, 4);  // upper tolerance edge
      ph[14] = mk(103, 1, 1'b1, 1'b0, 1'b1, 103, 1'b0, 4);  // edge beats timeout
      ph[15] = mk( 97, 1, 1'b1, 1'b0, 1'b1,  97, 1'b0, 4);
      ph[16] = mk(100, 1, 1'b1, 1'b0, 1'b1, 100, 1'b1, 4);
      ph[17] = mk( 97, 1, 1'b1, 1'b0, 1'b1,  97, 1'b0, 4);
      ph[18] = mk(150, 1, 1'b1, 1'b0, 1'b1, 150, 1'b0, 4);  // acquire timeout, no miss
      ph[19] = mk(100, 1, 1'b1, 1'b0, 1'b1, 100, 1'b1, 4);

      RST = 1'b1;
      pps_in = 1'b0;
      enable = 1'b1;
      force_free = 1'b0;
      model_reset();
      repeat (2) @(negedge CLK);
      chk("reset pps_out", int'(pps_out), 0);
      chk("reset pps_tick", int'(pps_tick), 0);
      chk("reset locked", int'(locked), 0);
      chk("reset period", int'(period), 0);
      chk("reset miss_cnt", int'(miss_cnt), 0);
      @(negedge CLK);
      RST = 1'b0;

      for (int i = 0; i < 20; i++) begin
         if (ph[i].npulse == 0) begin
            for (int c = 0; c < ph[i].gap; c++) step(1'b0, ph[i].en, ph[i].ff);
         end else begin
            for (int j = 0; j < ph[i].npulse; j++) pulse(ph[i].gap, P, ph[i].en, ph[i].ff);
         end
         chk($sformatf("phase%0d locked", i), int'(locked), int'(ph[i].exp_lock));
         chk($sformatf("phase%0d miss_cnt", i), int'(miss_cnt), ph[i].exp_miss);
         if (ph[i].chk_per) chk($sformatf("phase%0d period", i), int'(period), ph[i].exp_per);
      end

      // Randomized windows, model-checked every cycle
      for (int i = 0; i < 40; i++) begin
         int gap;
         int hi;
         bit en;
         bit ff;
         gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 230))
                                           : int'($urandom_range(96, 104));
         hi  = int'($urandom_range(1, 10));
         en  = ($urandom_range(0, 4) != 0);
         ff  = ($urandom_range(0, 3) == 0);
         pulse(gap, hi, en, ff);
      end

      // Relock, then a long outage saturates the miss counter
      for (int j = 0; j < 3; j++) pulse(100, P, 1'b1, 1'b0);
      chk("relock locked", int'(locked), 1);
      for (int c = 0; c < 26000; c++) step(1'b0, 1'b1, 1'b0);
      chk("miss saturation", int'(miss_cnt), 255);

      // Asynchronous reset five cycles into an output pulse
      found = 0;
      for (int c = 0; c < 200 && found == 0; c++) begin
         step(1'b0, 1'b1, 1'b0);
         if (pps_tick) found = 1;
      end
      chk("tick before reset", found, 1);
      for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0);
      chk("pulse high before reset", int'(pps_out), 1);
      pps_in = 1'b1;
      #2 RST = 1'b1;
      #1;
      chk("async reset pps_out", int'(pps_out), 0);
      chk("async reset pps_tick", int'(pps_tick), 0);
      chk("async reset locked", int'(locked), 0);
      chk("async reset period", int'(period), 0);
      chk("async reset miss_cnt", int'(miss_cnt), 0);
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      model_reset();
      // pps_in high across release must not count as an edge
      for (int c = 0; c < 20; c++) step(1'b1, 1'b1, 1'b0);
      for (int c = 0; c < 10; c++) step(1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 10; c++) step(1'b1, 1'b1, 1'b0);
      chk("first edge after reset period", int'(period), 33);
      chk("first edge after reset locked", int'(locked), 0);
      for (int j = 0; j < 2; j++) pulse(100, P, 1'b1, 1'b0);
      chk("lock after reset", int'(locked), 1);
      chk("period after reset", int'(period), 100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pps_sync_gen.md
PPS_SYNC_GEN -- requirements
Module: pps_sync_gen

Interface
REQ-001 Parameter NOMINAL, default 125000000, nominal CLK cycles per PPS second.
REQ-002 Parameter TOL, default 1250, permitted +/- deviation of a measured period, in cycles.
REQ-003 Parameter PULSE_W, default 12500000, width of the pps_out high pulse, in cycles (1 <= PULSE_W < NOMINAL).
REQ-004 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 pps_in  input  1  external PPS, asynchronous to CLK.
REQ-007 enable  input  1  1 = outputs active; 0 = pps_out and pps_tick forced low.
REQ-008 force_free  input  1  1 = generator ignores external edges and free-runs.
REQ-009 pps_out  output  1  generated PPS pulse, PULSE_W cycles high.
REQ-010 pps_tick  output  1  one-cycle strobe, coincident with each pps_out rising cycle.
REQ-011 locked  output  1  high while state == LOCKED.
REQ-012 period  output  32  last measured external period, in cycles.
REQ-013 miss_cnt  output  8  count of missed seconds, saturating at 255.

Function
REQ-014 pps_in SHALL pass through a 2-flop synchronizer (s1, s2) plus a history flop s3; ext_edge = s2 & ~s3.
REQ-015 ext_edge SHALL assert on the 3rd CLK rising edge after pps_in rises with setup met, and for exactly 1 cycle per rising edge.
REQ-016 Counter ctr (32 bit) SHALL clear to 0 in the cycle after ext_edge, otherwise increment, saturating at 2^32-1.
REQ-017 On ext_edge the measured period SHALL be ctr+1; period SHALL load this value; valid = |ctr+1 - NOMINAL| <= TOL.
REQ-018 States SHALL be UNLOCKED, ACQUIRE, LOCKED, HOLDOVER.
REQ-019 UNLOCKED: ext_edge -> ACQUIRE.
REQ-020 ACQUIRE: valid edge -> LOCKED; invalid edge -> ACQUIRE (ctr restarts); ctr == NOMINAL+TOL with no edge -> UNLOCKED.
REQ-021 LOCKED: valid edge -> LOCKED; invalid edge -> ACQUIRE; ctr == NOMINAL+TOL with no edge -> HOLDOVER and miss_cnt+1.
REQ-022 HOLDOVER: ext_edge -> ACQUIRE; each further NOMINAL cycles without an edge -> miss_cnt+1.
REQ-023 Generator counter gen (0..NOMINAL-1) SHALL run in every state: at gen == NOMINAL-1 it wraps to 0 and a tick fires.
REQ-024 Resync: a valid edge that leaves the state at or enters LOCKED, with force_free=0, SHALL set gen=0 and fire a tick in the next cycle, cancelling any wrap tick in that same cycle.
REQ-025 Tick cycle: pps_tick=1 and pps_out=1, and a width counter loads PULSE_W-1; pps_out SHALL stay high until the width counter reaches 0.
REQ-026 A tick while pps_out is already high SHALL restart the width count; at most one tick per cycle.
REQ-027 enable=0: gen held at 0, width counter cleared, pps_out=pps_tick=0; the state machine, period and miss_cnt continue.
REQ-028 enable 0->1: gen resumes from 0; the first tick comes at the next resync or after NOMINAL cycles.
REQ-029 force_free=1: resyncs suppressed; measurement and state machine unaffected.
REQ-030 A simultaneous ext_edge and timeout SHALL give priority to the edge.

Reset
REQ-031 RST=1 SHALL asynchronously set s1=s2=s3=0, ctr=0, gen=0, width=0, state=UNLOCKED, pps_out=0, pps_tick=0, locked=0, period=0, miss_cnt=0.
REQ-032 Reset mid-pulse SHALL drop pps_out immediately; after release, an edge is only detected once pps_in is sampled 0 then 1.

Verification (NOMINAL=100, TOL=2, PULSE_W=10)
REQ-033 Reset, then pps_in pulses every 100 cycles -> 2nd edge sets locked=1 and period=100; pps_tick fires 1 cycle after each ext_edge; pps_out high for 10 cycles.
REQ-034 Locked, then pps_in stops -> at ctr=102 state goes to HOLDOVER with miss_cnt=1 and locked=0; pps_tick continues every 100 cycles; miss_cnt=2 after 100 more cycles.
REQ-035 Locked, then one edge arrives at period 95 -> period=95, state=ACQUIRE, locked=0, no resync tick; the next edge at 100 relocks.
REQ-036 force_free=1 with edges at a 100-cycle pace offset 37 cycles from gen -> ticks stay on gen wrap; locked=1.
REQ-037 enable=0 for 250 cycles while locked -> pps_out=pps_tick=0 throughout, period still updates; on enable=1 ticks resume at the next edge.
REQ-038 RST asserted 5 cycles into a pps_out pulse -> pps_out=0 in the same cycle, all outputs at reset values.
